secuenciador_seleccion_byte: RTL and testbench

- Generates the byte-selection sequence consumed by the byte-select decoder (0..3 -> 000/001/011/111) that drives the mux selects of a 5x5 kernel line.
- Walks every kernel line and every byte position within it, one step per accepted handshake.
- Flags the last byte of each line and signals kernel completion.
- Sits between the filter control unit (source of `iniciar`) and the line-mux datapath.

---
 rtl/secuenciador_seleccion_byte.sv | 163 ++++++++++++++++
 tb/tb_secuenciador_seleccion_byte.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_seleccion_byte.sv
// Byte-selection sequencer for a 5x5 kernel line mux.
// Walks every kernel line and every byte position within it, advancing one
// step per accepted handshake (valido && listo_sig). It flags the last byte
// of each line and pulses fin_kernel once a sweep completes.
// Optional macro SECUENCIA_TERMOMETRO_EN adds a registered thermometer-coded
// 'configuracion' output that is aligned with 'seleccion'.
module secuenciador_seleccion_byte #(
    parameter int unsigned LINEAS          = 5,
    parameter int unsigned BYTES_POR_LINEA = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       listo_sig,
    output logic [1:0] seleccion,
    output logic [2:0] linea,
    output logic       valido,
    output logic       ultimo_byte,
    output logic       fin_kernel,
    output logic       ocupado
`ifdef SECUENCIA_TERMOMETRO_EN
    ,
    output logic [2:0] configuracion
`endif
);

    localparam int unsigned SEL_W = 2;
    localparam int unsigned LIN_W = 3;
    localparam int unsigned CFG_W = 3;

    localparam logic [SEL_W-1:0] SEL_ULTIMO = SEL_W'(BYTES_POR_LINEA - 1);
    localparam logic [LIN_W-1:0] LIN_ULTIMA = LIN_W'(LINEAS - 1);

    // Reject parameter values the 2-bit / 3-bit outputs cannot represent
    if (LINEAS == 0 || LINEAS > 8) begin : g_lineas_invalido
        $error("LINEAS must be in 1..8");
    end
    if (BYTES_POR_LINEA == 0 || BYTES_POR_LINEA > 4) begin : g_bytes_invalido
        $error("BYTES_POR_LINEA must be in 1..4");
    end

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        BARRIDO = 2'd1,
        FIN     = 2'd2
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [SEL_W-1:0]  seleccion_q, seleccion_d;
    logic [LIN_W-1:0]  linea_q, linea_d;
    logic              valido_q, valido_d;
    logic              fin_kernel_q, fin_kernel_d;
    logic              ocupado_q, ocupado_d;
    logic              transferencia_c;

`ifdef SECUENCIA_TERMOMETRO_EN
    logic [CFG_W-1:0]  configuracion_q, configuracion_d;
`endif

    // A step is consumed when the downstream mux accepts the current selection
    assign transferencia_c = valido_q && listo_sig;

    // Next-state and next-output logic; outputs derive from the next state so
    // they are registered yet still change in the same cycle as the state
    always_comb begin
        estado_d    = estado_q;
        seleccion_d = seleccion_q;
        linea_d     = linea_q;

        unique case (estado_q)
            REPOSO: begin
                if (iniciar) begin
                    estado_d    = BARRIDO;
                    seleccion_d = '0;
                    linea_d     = '0;
                end
            end
            BARRIDO: begin
                if (transferencia_c) begin
                    if (seleccion_q != SEL_ULTIMO) begin
                        seleccion_d = seleccion_q + SEL_W'(1);
                    end else if (linea_q != LIN_ULTIMA) begin
                        seleccion_d = '0;
                        linea_d     = linea_q + LIN_W'(1);
                    end else begin
                        estado_d    = FIN;
                        seleccion_d = '0;
                        linea_d     = '0;
                    end
                end
            end
            FIN: begin
                estado_d = REPOSO;
            end
            default: begin
                estado_d    = REPOSO;
                seleccion_d = '0;
                linea_d     = '0;
            end
        endcase

        valido_d     = (estado_d == BARRIDO);
        fin_kernel_d = (estado_d == FIN);
        ocupado_d    = (estado_d != REPOSO);
    end

`ifdef SECUENCIA_TERMOMETRO_EN
    // Thermometer code of the next selection, forced to zero outside a valid step
    always_comb begin
        configuracion_d = '0;
        if (valido_d) begin
            unique case (seleccion_d)
                2'd0:    configuracion_d = 3'b000;
                2'd1:    configuracion_d = 3'b001;
                2'd2:    configuracion_d = 3'b011;
                2'd3:    configuracion_d = 3'b111;
                default: configuracion_d = 3'b000;
            endcase
        end
    end
`endif

    // State and output registers; reset overrides any transfer in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q     <= REPOSO;
            seleccion_q  <= '0;
            linea_q      <= '0;
            valido_q     <= 1'b0;
            fin_kernel_q <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            seleccion_q  <= seleccion_d;
            linea_q      <= linea_d;
            valido_q     <= valido_d;
            fin_kernel_q <= fin_kernel_d;
            ocupado_q    <= ocupado_d;
        end
    end

`ifdef SECUENCIA_TERMOMETRO_EN
    // Thermometer register, kept beside seleccion so both update together
    always_ff @(posedge clk) begin
        if (reset) begin
            configuracion_q <= '0;
        end else begin
            configuracion_q <= configuracion_d;
        end
    end

    assign configuracion = configuracion_q;
`endif

    assign seleccion   = seleccion_q;
    assign linea       = linea_q;
    assign valido      = valido_q;
    assign fin_kernel  = fin_kernel_q;
    assign ocupado     = ocupado_q;
    // Last-byte flag is decoded directly from the registered selection
    assign ultimo_byte = valido_q && (seleccion_q == SEL_ULTIMO);

endmodule

// File: tb/tb_secuenciador_seleccion_byte.sv
// Bench for secuenciador_seleccion_byte: a default instance (5x4) and a
// 3-line, 1-byte instance share stimulus; each is compared every cycle with a
// transfer-count model (step index k -> linea = k / B, seleccion = k % B).
module tb_secuenciador_seleccion_byte;

    localparam int NI = 2;

    logic clk = 1'b0;
    logic reset, iniciar, listo_sig;

    logic [1:0] sel [NI];
    logic [2:0] lin [NI];
    logic       val [NI];
    logic       ult [NI];
    logic       fin [NI];
    logic       ocu [NI];
`ifdef SECUENCIA_TERMOMETRO_EN
    logic [2:0] cfg [NI];
`endif

    always #5 clk = ~clk;

    secuenciador_seleccion_byte dut_a (
        .clk(clk), .reset(reset), .iniciar(iniciar), .listo_sig(listo_sig),
        .seleccion(sel[0]), .linea(lin[0]), .valido(val[0]),
        .ultimo_byte(ult[0]), .fin_kernel(fin[0]), .ocupado(ocu[0])
`ifdef SECUENCIA_TERMOMETRO_EN
        , .configuracion(cfg[0])
`endif
    );

    secuenciador_seleccion_byte #(.LINEAS(3), .BYTES_POR_LINEA(1)) dut_b (
        .clk(clk), .reset(reset), .iniciar(iniciar), .listo_sig(listo_sig),
        .seleccion(sel[1]), .linea(lin[1]), .valido(val[1]),
        .ultimo_byte(ult[1]), .fin_kernel(fin[1]), .ocupado(ocu[1])
`ifdef SECUENCIA_TERMOMETRO_EN
        , .configuracion(cfg[1])
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    int nl [NI] = '{5, 3};
    int nb [NI] = '{4, 1};

    // Model: active sweep flag, step index within the sweep, pending fin pulse
    bit m_act [NI];
    bit m_fin [NI];
    int m_idx [NI];
    int dut_xfers [NI];
    int ult_seen  [NI];
    int fin_pulses [NI];

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < NI; i++) begin
            int e_sel, e_lin;
            string p;
            p = $sformatf("dut%0d", i);
            e_sel = m_act[i] ? (m_idx[i] % nb[i]) : 0;
            e_lin = m_act[i] ? (m_idx[i] / nb[i]) : 0;
            check({p, ".valido"},      int'(val[i]), int'(m_act[i]));
            check({p, ".seleccion"},   int'(sel[i]), e_sel);
            check({p, ".linea"},       int'(lin[i]), e_lin);
            check({p, ".ultimo_byte"}, int'(ult[i]),
                  int'(m_act[i] && (e_sel == nb[i] - 1)));
            check({p, ".fin_kernel"},  int'(fin[i]), int'(m_fin[i]));
            check({p, ".ocupado"},     int'(ocu[i]), int'(m_act[i] || m_fin[i]));
`ifdef SECUENCIA_TERMOMETRO_EN
            check({p, ".configuracion"}, int'(cfg[i]),
                  m_act[i] ? ((1 << e_sel) - 1) : 0);
`endif
            if (fin[i] === 1'b1) begin
                fin_pulses[i]++;
                check({p, ".transfers_per_sweep"}, dut_xfers[i], nl[i] * nb[i]);
                check({p, ".last_byte_flags"}, ult_seen[i], nl[i]);
                dut_xfers[i] = 0;
                ult_seen[i]  = 0;
            end
        end
    endtask

    task automatic model_step(input bit ini, input bit rdy, input bit rst);
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                m_act[i] = 0;
                m_fin[i] = 0;
                m_idx[i] = 0;
            end else if (m_act[i]) begin
                if (rdy) begin
                    m_idx[i]++;
                    if (m_idx[i] == nl[i] * nb[i]) begin
                        m_act[i] = 0;
                        m_fin[i] = 1;
                        m_idx[i] = 0;
                    end
                end
            end else if (m_fin[i]) begin
                m_fin[i] = 0;
            end else if (ini) begin
                m_act[i] = 1;
                m_idx[i] = 0;
            end
        end
    endtask

    // One clock: check at the falling edge, apply inputs, advance the model
    task automatic cycle(input bit ini, input bit rdy, input bit rst);
        check_outputs();
        reset     = rst;
        iniciar   = ini;
        listo_sig = rdy;
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                dut_xfers[i] = 0;
                ult_seen[i]  = 0;
            end else if (val[i] === 1'b1 && rdy) begin
                dut_xfers[i]++;
                if (ult[i] === 1'b1) ult_seen[i]++;
            end
        end
        model_step(ini, rdy, rst);
        @(negedge clk);
    endtask

    initial begin
        int fin_before;
        reset = 1'b1;
        iniciar = 1'b0;
        listo_sig = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_act[i] = 0; m_fin[i] = 0; m_idx[i] = 0;
            dut_xfers[i] = 0; ult_seen[i] = 0; fin_pulses[i] = 0;
        end
        repeat (2) @(negedge clk);

        // Reset state held
        cycle(0, 1, 1);
        cycle(0, 0, 0);

        // Full sweep at maximum throughput
        fin_before = fin_pulses[0];
        cycle(1, 1, 0);
        repeat (24) cycle(0, 1, 0);
        check("dut0.fin_pulses_full_sweep", fin_pulses[0] - fin_before, 1);

        // Back-pressure at linea=2, seleccion=1
        cycle(1, 1, 0);
        for (int k = 0; k < 40 && m_idx[0] != 9; k++) cycle(0, 1, 0);
        repeat (3) cycle(0, 0, 0);
        check("dut0.frozen_seleccion", int'(sel[0]), 1);
        check("dut0.frozen_linea", int'(lin[0]), 2);
        repeat (15) cycle(0, 1, 0);

        // iniciar mid-sweep is ignored
        fin_before = fin_pulses[0];
        cycle(1, 1, 0);
        for (int k = 0; k < 40 && m_idx[0] != 12; k++) cycle(0, 1, 0);
        cycle(1, 1, 0);
        repeat (12) cycle(0, 1, 0);
        check("dut0.fin_pulses_ignored_start", fin_pulses[0] - fin_before, 1);

        // Reset at linea=1, seleccion=3, then reset together with iniciar
        cycle(1, 1, 0);
        for (int k = 0; k < 40 && m_idx[0] != 7; k++) cycle(0, 1, 0);
        cycle(0, 1, 1);
        cycle(1, 1, 1);
        cycle(0, 1, 0);
        cycle(1, 1, 0);
        repeat (25) cycle(0, 1, 0);

        // Back-to-back sweeps with the minimum gap
        cycle(1, 1, 0);
        repeat (21) cycle(0, 1, 0);
        cycle(1, 1, 0);
        repeat (24) cycle(0, 1, 0);

        // Randomised handshake, start and reset traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 250) == 0);
        end
        cycle(0, 0, 0);

        check("dut0.any_fin_seen", int'(fin_pulses[0] > 5), 1);
        check("dut1.any_fin_seen", int'(fin_pulses[1] > 5), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
